// File: rtl/activation_request_sequencer.sv
// Host-side sequencer for the activation lookup unit: issues one neuron sum at a time,
// waits for a non-stale non-zero tag (or a timeout), then hands the result downstream.
module activation_request_sequencer #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Settle    = 2,
    parameter int unsigned Timeout   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_sum_i,
    input  logic                 in_func_i,
    output logic [DataWidth-1:0] act_sum_o,
    output logic                 act_func_o,
    input  logic [DataWidth-1:0] act_value_i,
    input  logic [DataWidth-1:0] act_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_value_o,
    output logic [DataWidth-1:0] out_sum_o,
    output logic                 out_timeout_o,
    output logic [15:0]          done_count_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);
    localparam logic [CntW-1:0] SettleC  = CntW'(Settle);
    localparam logic [CntW-1:0] TimeoutC = CntW'(Timeout);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic [DataWidth-1:0]  act_sum_q, act_sum_d;
    logic                  act_func_q, act_func_d;
    logic [DataWidth-1:0]  out_value_q, out_value_d;
    logic [DataWidth-1:0]  out_sum_q, out_sum_d;
    logic                  out_timeout_q, out_timeout_d;
    logic [15:0]           done_count_q, done_count_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        act_sum_d     = act_sum_q;
        act_func_d    = act_func_q;
        out_value_d   = out_value_q;
        out_sum_d     = out_sum_q;
        out_timeout_d = out_timeout_q;
        done_count_d  = done_count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i && in_ready_q) begin
                    act_sum_d  = in_sum_i;
                    act_func_d = in_func_i;
                    cnt_d      = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntW'(1);
                state_d = StWait;
            end
            StWait: begin
                // A tag on the timeout cycle still counts as a match.
                if (cnt_q > SettleC && act_tag_i != '0) begin
                    out_value_d   = act_value_i;
                    out_sum_d     = act_sum_q;
                    out_timeout_d = 1'b0;
                    state_d       = StHold;
                end else if (cnt_q == TimeoutC) begin
                    out_value_d   = '0;
                    out_sum_d     = act_sum_q;
                    out_timeout_d = 1'b1;
                    state_d       = StHold;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    done_count_d = done_count_q + 16'd1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so in_ready stays low through reset and rises one cycle after release.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            in_ready_q    <= 1'b0;
            act_sum_q     <= '0;
            act_func_q    <= 1'b0;
            out_value_q   <= '0;
            out_sum_q     <= '0;
            out_timeout_q <= 1'b0;
            done_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            act_sum_q     <= act_sum_d;
            act_func_q    <= act_func_d;
            out_value_q   <= out_value_d;
            out_sum_q     <= out_sum_d;
            out_timeout_q <= out_timeout_d;
            done_count_q  <= done_count_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign act_sum_o     = act_sum_q;
    assign act_func_o    = act_func_q;
    assign out_valid_o   = (state_q == StHold);
    assign out_value_o   = out_value_q;
    assign out_sum_o     = out_sum_q;
    assign out_timeout_o = out_timeout_q;
    assign done_count_o  = done_count_q;

endmodule
